mac_seq: RTL

Job sequencer for the shared `mac` datapath. It accepts a dot-product job, then streams operand pairs into the MAC as one MUL followed by MAC accumulates. It optionally issues a saturate, drains the MAC's two-deep output pipeline, and presents the final accumulator on a valid/ready result port. It sits between operand-producing logic and one `mac` instance, and owns all of that instance's control inputs.

---
 rtl/mac_seq_pkg.sv | 26 ++
 rtl/mac_seq.sv | 125 ++++++++++++
 2 files changed

// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: opcodes, FSM states and mode-to-opcode mapping shared by mac_seq
// MAC_SEQ_SAT_EN adds the SAT state to the enum.
package mac_seq_pkg;
  localparam logic [2:0] OP_CLR   = 3'b000;
  localparam logic [2:0] OP_MUL   = 3'b001;
  localparam logic [2:0] OP_MAC   = 3'b010;
  localparam logic [2:0] OP_SAT   = 3'b011;
  localparam logic [2:0] OP_CLR16 = 3'b100;
  localparam logic [2:0] OP_MUL16 = 3'b101;
  localparam logic [2:0] OP_MAC16 = 3'b110;
  localparam logic [2:0] OP_SAT16 = 3'b111;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FIRST,
    S_ACC,
`ifdef MAC_SEQ_SAT_EN
    S_SAT,
`endif
    S_DRAIN,
    S_OUT
  } state_t;
  // Dual-lane opcodes are the 32-bit opcodes with bit 2 set.
  function automatic logic [2:0] mode_op(input logic dual, input logic [2:0] op);
    return op | {dual, 2'b00};
  endfunction
endpackage

// File: rtl/mac_seq.sv
// mac_seq: job sequencer that owns one mac instance (MUL, MAC stream, optional SAT, drain, result handshake)
// Ports: job_valid/job_ready/job_len/job_dual/job_sat accept a job; op_valid/op_ready/op_a/op_b
// stream operand pairs; mac_instruction/mac_multiplier/mac_multiplicand/mac_stall drive the mac and
// mac_protect/mac_result come back from it; res_valid/res_ready/res_data/res_guard present the result;
// busy is high whenever a job is in flight. clk, reset_n (asynchronous, active-low).
// Build option: define MAC_SEQ_SAT_EN to honour job_sat (adds the SAT state); undefined ignores job_sat.
module mac_seq
  import mac_seq_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [LEN_W-1:0] job_len,
  input  logic             job_dual,
  input  logic             job_sat,
  input  logic             op_valid,
  output logic             op_ready,
  input  logic [15:0]      op_a,
  input  logic [15:0]      op_b,
  output logic [2:0]       mac_instruction,
  output logic [15:0]      mac_multiplier,
  output logic [15:0]      mac_multiplicand,
  output logic             mac_stall,
  input  logic [7:0]       mac_protect,
  input  logic [31:0]      mac_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_data,
  output logic [7:0]       res_guard,
  output logic             busy
);
  state_t state, state_nx, post;
  logic [LEN_W-1:0] cnt, cnt_nx;
  logic dual_q, take, clr;
`ifdef MAC_SEQ_SAT_EN
  logic sat_q;
  assign post = sat_q ? S_SAT : S_DRAIN;
`else
  logic unused_sat;
  assign unused_sat = job_sat;
  assign post = S_DRAIN;
`endif
  // A zero-length job spends its FIRST cycle clearing the accumulator instead of taking a pair.
  assign clr       = state == S_FIRST && cnt == '0;
  assign op_ready  = (state == S_FIRST || state == S_ACC) && cnt != '0;
  assign take      = op_ready && op_valid;
  assign job_ready = state == S_IDLE;
  assign busy      = state != S_IDLE;
  assign res_valid = state == S_OUT;
  // The mac is stalled in OUT, so its outputs already hold the final accumulator.
  assign res_data  = mac_result;
  assign res_guard = mac_protect;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      dual_q <= 1'b0;
`ifdef MAC_SEQ_SAT_EN
      sat_q  <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (job_valid && job_ready) begin
        dual_q <= job_dual;
`ifdef MAC_SEQ_SAT_EN
        sat_q  <= job_sat;
`endif
      end
    end
  // cnt counts remaining pairs in FIRST/ACC and is reused as the drain cycle index in DRAIN.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      S_IDLE: if (job_valid) begin
        state_nx = S_FIRST;
        cnt_nx   = job_len;
      end
      S_FIRST, S_ACC: begin
        if (take) cnt_nx = cnt - LEN_W'(1);
        if (clr || (take && cnt == LEN_W'(1))) state_nx = post;
        else if (take) state_nx = S_ACC;
      end
`ifdef MAC_SEQ_SAT_EN
      S_SAT: state_nx = S_DRAIN;
`endif
      S_DRAIN: begin
        cnt_nx   = cnt == '0 ? LEN_W'(1) : '0;
        state_nx = cnt == '0 ? S_DRAIN : S_OUT;
      end
      S_OUT: if (res_ready) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end
  always_comb begin
    mac_stall        = 1'b1;
    mac_instruction  = OP_CLR;
    mac_multiplier   = '0;
    mac_multiplicand = '0;
    case (state)
      S_FIRST, S_ACC: begin
        mac_stall        = !(clr || take);
        mac_instruction  = mode_op(dual_q, clr ? OP_CLR : state == S_FIRST ? OP_MUL : OP_MAC);
        mac_multiplier   = take ? op_a : '0;
        mac_multiplicand = take ? op_b : '0;
      end
`ifdef MAC_SEQ_SAT_EN
      S_SAT: begin
        mac_stall       = 1'b0;
        mac_instruction = mode_op(dual_q, OP_SAT);
      end
`endif
      // Zero-operand MACs push the final accumulator through the mac's output pipeline.
      S_DRAIN: begin
        mac_stall       = 1'b0;
        mac_instruction = mode_op(dual_q, OP_MAC);
      end
      default: ;
    endcase
  end
endmodule
